// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice.
// Contents: FSM state encoding and the default timing constants used by
// top-level instantiations (12 MHz clock, 100 Hz count tick).
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam int unsigned TICK_DIV_DEFAULT        = 120000;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 12000;
    localparam int unsigned LAP_HOLD_DEFAULT        = 200;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser followed by a debounce counter.
// Ports:
//   CLK   - clock
//   RST   - synchronous reset, active-high
//   raw   - raw button input, asynchronous to CLK
//   level - debounced button level
//   press - 1-cycle pulse when the debounced level rises (releases give nothing)
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles where the synchronised input disagrees
    // with the debounced level; any agreement cycle restarts it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    press <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounces the four buttons, runs the
// IDLE/RUN/PAUSE FSM, divides CLK down to the count tick and times the
// lap-display hold. Owns no digit data.
// Ports:
//   CLK, RST                      - clock, synchronous active-high reset
//   btn_start/lap/stop/clear      - raw active-high buttons
//   cnt_en   - 1-cycle strobe: advance the BCD count
//   cnt_clr  - 1-cycle strobe: zero the count
//   lap_load - 1-cycle strobe: copy live count into the lap register
//   lap_show - level: display the lap register
//   running  - level: FSM is in RUN
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV        = TICK_DIV_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned LAP_HOLD        = LAP_HOLD_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_start,
    input  logic btn_lap,
    input  logic btn_stop,
    input  logic btn_clear,
    output logic cnt_en,
    output logic cnt_clr,
    output logic lap_load,
    output logic lap_show,
    output logic running
);

    localparam int unsigned DW = $clog2(TICK_DIV);

    // bit order: 0 start, 1 lap, 2 stop, 3 clear
    logic [3:0] raw_btn;
    logic [3:0] press;

    assign raw_btn = {btn_clear, btn_stop, btn_lap, btn_start};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .CLK  (CLK),
            .RST  (RST),
            .raw  (raw_btn[i]),
            .level(),
            .press(press[i])
        );
    end

    // Same-cycle priority: clear > stop > start > lap.
    logic ev_clear, ev_stop, ev_start, ev_lap;

    always_comb begin
        ev_clear = press[3];
        ev_stop  = press[2] & ~press[3];
        ev_start = press[0] & ~press[2] & ~press[3];
        ev_lap   = press[1] & ~press[0] & ~press[2] & ~press[3];
    end

    sw_state_t       state, state_n;
    logic [DW-1:0]   div, div_n;
    logic [7:0]      hold, hold_n;
    logic            en_n, clr_n, ld_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            div      <= '0;
            hold     <= '0;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            lap_load <= 1'b0;
            lap_show <= 1'b0;
            running  <= 1'b0;
        end else begin
            state    <= state_n;
            div      <= div_n;
            hold     <= hold_n;
            cnt_en   <= en_n;
            cnt_clr  <= clr_n;
            lap_load <= ld_n;
            lap_show <= (hold_n != '0);
            running  <= (state_n == RUN);
        end
    end

    // Divider and hold counter advance first; button events then override,
    // so a clear wins over a coincident tick and a lap load over a decrement.
    always_comb begin
        state_n = state;
        div_n   = div;
        hold_n  = hold;
        en_n    = 1'b0;
        clr_n   = 1'b0;
        ld_n    = 1'b0;

        if (state == RUN) begin
            if (div == DW'(TICK_DIV - 1)) begin
                div_n = '0;
                en_n  = 1'b1;
            end else begin
                div_n = div + DW'(1);
            end
        end

        if (cnt_en && (hold != '0)) begin
            hold_n = hold - 8'd1;
        end

        if (ev_clear) begin
            state_n = IDLE;
            div_n   = '0;
            hold_n  = '0;
            en_n    = 1'b0;
            clr_n   = 1'b1;
        end else if (ev_stop) begin
            hold_n = '0;
            if (state == RUN) begin
                state_n = PAUSE;
            end
        end else if (ev_start) begin
            unique case (state)
                IDLE: begin
                    state_n = RUN;
                    div_n   = '0;
                end
                PAUSE:   state_n = RUN;
                default: state_n = state;
            endcase
        end else if (ev_lap && (state == RUN)) begin
            hold_n = 8'(LAP_HOLD);
            ld_n   = 1'b1;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam int TD = 10;
    localparam int DB = 4;
    localparam int LH = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic btn_start = 1'b0, btn_lap = 1'b0, btn_stop = 1'b0, btn_clear = 1'b0;
    logic cnt_en, cnt_clr, lap_load, lap_show, running;

    always #5 CLK = ~CLK;

    stopwatch_ctrl #(
        .TICK_DIV       (TD),
        .DEBOUNCE_CYCLES(DB),
        .LAP_HOLD       (LH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .btn_start(btn_start),
        .btn_lap  (btn_lap),
        .btn_stop (btn_stop),
        .btn_clear(btn_clear),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .lap_load (lap_load),
        .lap_show (lap_show),
        .running  (running)
    );

    // Scoreboard: expected {cnt_en, cnt_clr, lap_load, lap_show, running}
    logic [4:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // Reference model state (button index: 0 start, 1 lap, 2 stop, 3 clear)
    int m_hist1[4];     // raw seen one edge ago
    int m_hist2[4];     // synchronised input
    int m_level[4];     // debounced level
    int m_streak[4];    // consecutive cycles input disagreed with level
    int m_evt[4];       // press event visible this cycle
    int m_mode;
    int m_phase;        // cycles elapsed in RUN modulo TD
    int m_hold;         // remaining ticks of lap display
    int m_en, m_clr, m_ld;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_hist1[i] = 0; m_hist2[i] = 0; m_level[i] = 0;
            m_streak[i] = 0; m_evt[i] = 0;
        end
        m_mode = M_IDLE; m_phase = 0; m_hold = 0;
        m_en = 0; m_clr = 0; m_ld = 0;
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_step(input logic [3:0] b, input logic r);
        int nevt[4];
        int clr_p, stop_p, start_p, lap_p;
        int prev_en;
        if (r) begin
            model_reset();
            return;
        end
        clr_p   = m_evt[3];
        stop_p  = m_evt[2] && !clr_p;
        start_p = m_evt[0] && !clr_p && !stop_p;
        lap_p   = m_evt[1] && !clr_p && !stop_p && !start_p;
        prev_en = m_en;

        for (int i = 0; i < 4; i++) begin
            nevt[i] = 0;
            if (m_hist2[i] != m_level[i]) begin
                m_streak[i]++;
                if (m_streak[i] == DB) begin
                    m_level[i]  = m_hist2[i];
                    nevt[i]     = m_level[i];
                    m_streak[i] = 0;
                end
            end else begin
                m_streak[i] = 0;
            end
            m_hist2[i] = m_hist1[i];
            m_hist1[i] = int'(b[i]);
        end

        m_en = 0; m_clr = 0; m_ld = 0;
        if (m_mode == M_RUN) begin
            m_phase = (m_phase + 1) % TD;
            m_en    = (m_phase == 0);
        end
        if (prev_en && m_hold > 0) m_hold--;

        if (clr_p) begin
            m_mode = M_IDLE; m_phase = 0; m_hold = 0; m_en = 0; m_clr = 1;
        end else if (stop_p) begin
            m_hold = 0;
            if (m_mode == M_RUN) m_mode = M_PAUSE;
        end else if (start_p) begin
            if (m_mode == M_IDLE) begin
                m_mode = M_RUN; m_phase = 0;
            end else if (m_mode == M_PAUSE) begin
                m_mode = M_RUN;
            end
        end else if (lap_p && m_mode == M_RUN) begin
            m_hold = LH; m_ld = 1;
        end
        for (int i = 0; i < 4; i++) m_evt[i] = nevt[i];
    endtask

    // Drive buttons/reset for n cycles; each cycle's expected outputs are queued.
    task automatic drive(input logic [3:0] b, input logic r, input int n);
        logic [4:0] e;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            btn_start = b[0]; btn_lap = b[1]; btn_stop = b[2]; btn_clear = b[3];
            RST = r;
            model_step(b, r);
            e = {m_en[0], m_clr[0], m_ld[0], (m_hold != 0), (m_mode == M_RUN)};
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare whatever the DUT presents after every edge.
    initial begin
        logic [4:0] e, a;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {cnt_en, cnt_clr, lap_load, lap_show, running};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t en/clr/ld/show/run got %b expected %b",
                             $time, a, e);
                end
            end
        end
    end

    initial begin
        logic [3:0] rb;
        int guard;
        model_reset();

        // Reset and idle
        drive(4'b0000, 1'b1, 3);
        drive(4'b0000, 1'b0, 50);
        // Short start glitch, then a long hold
        drive(4'b0001, 1'b0, 3);
        drive(4'b0000, 1'b0, 20);
        drive(4'b0001, 1'b0, 20);
        drive(4'b0000, 1'b0, 35);
        // Stop aligned so the state change lands 4 cycles after a tick
        guard = 0;
        while (!(m_mode == M_RUN && m_phase == TD - 3) && guard < 50) begin
            drive(4'b0000, 1'b0, 1);
            guard++;
        end
        drive(4'b0100, 1'b0, 8);
        drive(4'b0000, 1'b0, 100);
        drive(4'b0001, 1'b0, 8);
        drive(4'b0000, 1'b0, 30);
        // Lap, full hold, then relap during hold, then stop during hold
        drive(4'b0010, 1'b0, 8);
        drive(4'b0000, 1'b0, 40);
        drive(4'b0010, 1'b0, 8);
        drive(4'b0000, 1'b0, 12);
        drive(4'b0010, 1'b0, 8);
        drive(4'b0000, 1'b0, 5);
        drive(4'b0100, 1'b0, 8);
        drive(4'b0000, 1'b0, 10);
        // Resume, then clear and start together
        drive(4'b0001, 1'b0, 8);
        drive(4'b0000, 1'b0, 15);
        drive(4'b1001, 1'b0, 8);
        drive(4'b0000, 1'b0, 30);
        // Lap in IDLE
        drive(4'b0010, 1'b0, 8);
        drive(4'b0000, 1'b0, 15);
        // Reset mid-run with lap shown, start held through reset
        drive(4'b0001, 1'b0, 8);
        drive(4'b0000, 1'b0, 12);
        drive(4'b0010, 1'b0, 8);
        drive(4'b0001, 1'b0, 2);
        drive(4'b0001, 1'b1, 2);
        drive(4'b0001, 1'b0, 12);
        drive(4'b0000, 1'b0, 20);

        // Randomised button activity with occasional resets
        rb = 4'b0000;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 11) == 0) rb[i] = ~rb[i];
            end
            drive(rb, ($urandom_range(0, 799) == 0), 1);
        end
        drive(4'b0000, 1'b0, 10);

        repeat (3) @(posedge CLK);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
